// File: rtl/ariane_axi_pkg.sv
// ariane_axi: AXI4 request/response structs used as default port types of the drain unit.
package ariane_axi;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

// File: rtl/std_cache_pkg.sv
// std_cache_pkg: drain FSM state encoding and default outstanding-transaction limits.
package std_cache_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} drain_state_e;

    localparam int unsigned DefaultMaxRdTxn = 4;
    localparam int unsigned DefaultMaxWrTxn = 4;
endpackage

// File: rtl/axi_txn_counter.sv
// axi_txn_counter: saturating up/down outstanding-transaction counter with clamped count output.
module axi_txn_counter #(
    parameter int unsigned Max = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       inc,
    input  logic                       dec,
    output logic [$clog2(Max+1)-1:0]   count,
    output logic                       limit,
    output logic                       zero
);
    localparam int unsigned CntW = $clog2(Max + 2);
    localparam int unsigned OutW = $clog2(Max + 1);

    // One slot above Max absorbs the transaction a held valid can push past the limit.
    logic [CntW-1:0] cnt, cnt_nxt;

    always_comb begin
        cnt_nxt = (inc && !dec) ? ((cnt == CntW'(Max + 1)) ? cnt : cnt + 1'b1)
                : (dec && !inc) ? ((cnt == '0) ? cnt : cnt - 1'b1)
                : cnt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            a_underflow: assert (!(dec && !inc && cnt == '0));
            cnt <= cnt_nxt;
        end
    end

    assign count = (cnt > CntW'(Max)) ? OutW'(Max) : cnt[OutW-1:0];
    assign limit = cnt >= CntW'(Max);
    assign zero  = cnt == '0;
endmodule

// File: rtl/cache_axi_drain_unit.sv
// cache_axi_drain_unit: gates new AR/AW on a cache AXI port to quiesce it on request,
// tracking outstanding reads and writes so the drain is acknowledged only once idle.
module cache_axi_drain_unit
    import std_cache_pkg::*;
#(
    parameter int unsigned AxiIdWidth = 4,
    parameter int unsigned MaxRdTxn   = DefaultMaxRdTxn,
    parameter int unsigned MaxWrTxn   = DefaultMaxWrTxn,
    parameter type         axi_req_t  = ariane_axi::req_t,
    parameter type         axi_rsp_t  = ariane_axi::resp_t
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            drain_req_i,
    output logic                            drain_ack_o,
    output logic                            busy_o,
    output logic [$clog2(MaxRdTxn+1)-1:0]   rd_outstanding_o,
    output logic [$clog2(MaxWrTxn+1)-1:0]   wr_outstanding_o,
    input  axi_req_t                        slv_req_i,
    output axi_rsp_t                        slv_resp_o,
    output axi_req_t                        mst_req_o,
    input  axi_rsp_t                        mst_resp_i
);
    if (AxiIdWidth < 1 || MaxRdTxn < 1 || MaxWrTxn < 1) begin : g_bad_param
        $error("cache_axi_drain_unit: AxiIdWidth, MaxRdTxn and MaxWrTxn must be >= 1");
    end

    drain_state_e state;
    logic ar_held, aw_held, fwd_ar, fwd_aw;
    logic ar_hs, aw_hs, r_done, b_done;
    logic rd_limit, wr_limit, rd_zero, wr_zero;

    // A valid already presented downstream stays forwarded until its handshake.
    always_comb begin
        fwd_ar              = ar_held || (state == RUN && !rd_limit);
        fwd_aw              = aw_held || (state == RUN && !wr_limit);
        mst_req_o           = slv_req_i;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && fwd_ar;
        mst_req_o.aw_valid  = slv_req_i.aw_valid && fwd_aw;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && fwd_ar;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && fwd_aw;
    end

    assign ar_hs  = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign aw_hs  = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign r_done = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign b_done = mst_resp_i.b_valid && slv_req_i.b_ready;

    axi_txn_counter #(.Max(MaxRdTxn)) u_rd_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (ar_hs),
        .dec   (r_done),
        .count (rd_outstanding_o),
        .limit (rd_limit),
        .zero  (rd_zero)
    );

    axi_txn_counter #(.Max(MaxWrTxn)) u_wr_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (aw_hs),
        .dec   (b_done),
        .count (wr_outstanding_o),
        .limit (wr_limit),
        .zero  (wr_zero)
    );

    assign busy_o = !rd_zero || !wr_zero || ar_held || aw_held;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= RUN;
            drain_ack_o <= 1'b0;
            ar_held     <= 1'b0;
            aw_held     <= 1'b0;
        end else begin
            ar_held <= mst_req_o.ar_valid && !mst_resp_i.ar_ready;
            aw_held <= mst_req_o.aw_valid && !mst_resp_i.aw_ready;
            case (state)
                RUN: if (drain_req_i) state <= DRAIN;
                DRAIN: begin
                    if (!drain_req_i) begin
                        state <= RUN;
                    end else if (!busy_o) begin
                        state       <= HALTED;
                        drain_ack_o <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!drain_req_i) begin
                        state       <= RUN;
                        drain_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= RUN;
                    drain_ack_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_drain_unit.sv
// tb_cache_axi_drain_unit: table-driven cycle vectors plus drain/passthrough sequences.
module tb_cache_axi_drain_unit;
    logic clk = 1'b0;
    logic rst_ni;
    logic drain_req;
    logic drain_ack;
    logic busy;
    logic [2:0] rd_out, wr_out;
    ariane_axi::req_t  slv_req, mst_req;
    ariane_axi::resp_t slv_resp, mst_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_axi_drain_unit dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .drain_req_i     (drain_req),
        .drain_ack_o     (drain_ack),
        .busy_o          (busy),
        .rd_outstanding_o(rd_out),
        .wr_outstanding_o(wr_out),
        .slv_req_i       (slv_req),
        .slv_resp_o      (slv_resp),
        .mst_req_o       (mst_req),
        .mst_resp_i      (mst_resp)
    );

    // in = {rst, drain, ar_valid, ar_ready, r_last_valid, aw_valid, aw_ready, b_valid}
    // comb = {slv ar_ready, mst ar_valid, slv aw_ready, mst aw_valid} before the edge
    typedef struct {
        bit [7:0] in;
        bit [3:0] comb;
        int       rd;
        int       wr;
        bit       ack;
        bit       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit [7:0] in, bit [3:0] comb, int rd, int wr, bit ack, bit bsy);
        vec_t v;
        v.in = in; v.comb = comb; v.rd = rd; v.wr = wr; v.ack = ack; v.busy = bsy;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(bit [7:0] in);
        rst_ni              = !in[7];
        drain_req           = in[6];
        slv_req.ar_valid    = in[5];
        mst_resp.ar_ready   = in[4];
        mst_resp.r_valid    = in[3];
        slv_req.aw_valid    = in[2];
        mst_resp.aw_ready   = in[1];
        mst_resp.b_valid    = in[0];
    endtask

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        slv_req.r_ready  = 1'b1;
        slv_req.b_ready  = 1'b1;
        mst_resp.r.last  = 1'b1;
        drain_req = 1'b0;
        rst_ni    = 1'b0;

        add(8'b0000_0000, 4'b0000, 0, 0, 0, 0);
        add(8'b0011_0000, 4'b1100, 1, 0, 0, 1);
        add(8'b0011_0000, 4'b1100, 2, 0, 0, 1);
        add(8'b0011_0000, 4'b1100, 3, 0, 0, 1);
        add(8'b0011_0000, 4'b1100, 4, 0, 0, 1);
        add(8'b0011_0000, 4'b0000, 4, 0, 0, 1);
        add(8'b0011_1000, 4'b0000, 3, 0, 0, 1);
        add(8'b0011_0000, 4'b1100, 4, 0, 0, 1);
        add(8'b0000_1000, 4'b0000, 3, 0, 0, 1);
        add(8'b0000_1000, 4'b0000, 2, 0, 0, 1);
        add(8'b0011_1000, 4'b1100, 2, 0, 0, 1);
        add(8'b0000_1000, 4'b0000, 1, 0, 0, 1);
        add(8'b0000_1000, 4'b0000, 0, 0, 0, 0);
        add(8'b0000_0110, 4'b0011, 0, 1, 0, 1);
        add(8'b0000_0110, 4'b0011, 0, 2, 0, 1);
        add(8'b0000_0100, 4'b0001, 0, 2, 0, 1);
        add(8'b0100_0100, 4'b0001, 0, 2, 0, 1);
        add(8'b0100_0110, 4'b0011, 0, 3, 0, 1);
        add(8'b0111_0110, 4'b0000, 0, 3, 0, 1);
        add(8'b0100_0111, 4'b0000, 0, 2, 0, 1);
        add(8'b0100_0001, 4'b0000, 0, 1, 0, 1);
        add(8'b0100_0001, 4'b0000, 0, 0, 0, 0);
        add(8'b0100_0000, 4'b0000, 0, 0, 1, 0);
        add(8'b0010_0000, 4'b0000, 0, 0, 0, 0);
        add(8'b0011_0000, 4'b1100, 1, 0, 0, 1);
        add(8'b0100_0000, 4'b0000, 1, 0, 0, 1);
        add(8'b0011_0000, 4'b0000, 1, 0, 0, 1);
        add(8'b0011_0000, 4'b1100, 2, 0, 0, 1);
        add(8'b0011_0110, 4'b1111, 3, 1, 0, 1);
        add(8'b0000_0110, 4'b0011, 3, 2, 0, 1);
        add(8'b1010_0100, 4'b0101, 0, 0, 0, 0);
        add(8'b0000_0000, 4'b0000, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", -1, drain_ack, 0);
        chk("reset_busy", -1, busy, 0);
        chk("reset_rd", -1, rd_out, 0);
        chk("reset_wr", -1, wr_out, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i].in);
            #1;
            chk("slv_ar_ready", i, slv_resp.ar_ready, tbl[i].comb[3]);
            chk("mst_ar_valid", i, mst_req.ar_valid, tbl[i].comb[2]);
            chk("slv_aw_ready", i, slv_resp.aw_ready, tbl[i].comb[1]);
            chk("mst_aw_valid", i, mst_req.aw_valid, tbl[i].comb[0]);
            @(posedge clk);
            #1;
            chk("rd_outstanding", i, rd_out, tbl[i].rd);
            chk("wr_outstanding", i, wr_out, tbl[i].wr);
            chk("drain_ack", i, drain_ack, tbl[i].ack);
            chk("busy", i, busy, tbl[i].busy);
        end

        // Idle drain must acknowledge within a bounded number of cycles.
        @(negedge clk);
        apply(8'b0100_0000);
        for (int c = 0; c < 8 && !drain_ack; c++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_drain_ack", 100, drain_ack, 1);
        chk("idle_drain_busy", 100, busy, 0);

        // While halted, payload and W still pass through but AR stays gated.
        @(negedge clk);
        slv_req.ar_valid   = 1'b1;
        slv_req.ar.addr    = 64'h1234_5678_9abc_def0;
        slv_req.w_valid    = 1'b1;
        mst_resp.w_ready   = 1'b1;
        mst_resp.r.data    = 64'h0000_0000_cafe_f00d;
        #1;
        chk("halt_w_valid", 101, mst_req.w_valid, 1);
        chk("halt_w_ready", 101, slv_resp.w_ready, 1);
        chk("halt_ar_addr", 101, mst_req.ar.addr, 64'h1234_5678_9abc_def0);
        chk("halt_r_data", 101, slv_resp.r.data, 64'h0000_0000_cafe_f00d);
        chk("halt_ar_gated", 101, mst_req.ar_valid, 0);

        // Releasing the drain returns to RUN and forwards the pending AR.
        @(negedge clk);
        drain_req = 1'b0;
        @(posedge clk);
        #1;
        chk("release_ack", 102, drain_ack, 0);
        chk("release_ar_fwd", 102, mst_req.ar_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
